pixel_word_packer: RTL and testbench
====================================

Name: pixel_word_packer

Overview:
- Upstream feeder of the bank distributor stage. Takes the decoded HDMI pixel stream, one PIXEL_BITS sample per colour channel per cycle.
- Packs PIXELS_PER_WORD consecutive samples per channel into one CHANNEL_BANDWIDTH-wide word.
- Generates the global write address (0..BLOCK_DEPTH-1) and a one-cycle write strobe that the distributor consumes.
- Handles frame restart and padded flush of partial words at line end.

Parameters:
- CHANNEL_NUMBER, 3, number of colour channels/banks.
- PIXEL_BITS, 8, bits per sample per channel.
- PIXELS_PER_WORD, 8, samples packed per output word.
- CHANNEL_BANDWIDTH, PIXEL_BITS*PIXELS_PER_WORD, output word width per channel.
- BLOCK_DEPTH, 12, number of word addresses per block before wrap.
- GLOBAL_ADDR_BITS, $clog2(BLOCK_DEPTH), address width.

Ports:
- I_clk_in  in  1  single clock; all logic on rising edge.
- I_rst_n_in  in  1  reset, synchronous, active-low.
- I_pixel_in  in  [PIXEL_BITS-1:0] x CHANNEL_NUMBER  sample per channel.
- I_valid_in  in  1  sample valid this cycle.
- I_frame_start_in  in  1  one-cycle pulse; restart packing and address.
- I_line_end_in  in  1  one-cycle pulse; flush partial word.
- O_data_out  out  [CHANNEL_BANDWIDTH-1:0] x CHANNEL_NUMBER  packed words.
- O_address_out  out  GLOBAL_ADDR_BITS  global word address of O_data_out.
- O_write_out  out  1  one-cycle strobe; data/address valid.
- O_block_done_out  out  1  pulses with the write at address BLOCK_DEPTH-1.

Behaviour:
- Reset (I_rst_n_in=0 at clock edge): state IDLE; pixel count 0; address counter 0; shift registers 0. All outputs are 0: O_data_out, O_address_out, O_write_out, O_block_done_out.
- FSM states:
  - IDLE: I_valid_in and I_line_end_in are ignored. I_frame_start_in moves to PACK.
  - PACK: accepts samples.
  - FLUSH: one cycle; emits the padded partial word, then returns to PACK.
- Packing order: k-th accepted sample of a word (k=0..PIXELS_PER_WORD-1) goes to bits [k*PIXEL_BITS +: PIXEL_BITS]. First sample lands in the LSBs. The same k applies to all channels.
- Full word: on the edge accepting sample k=PIXELS_PER_WORD-1, the word is registered to O_data_out. O_write_out=1 in the following cycle (latency 1 from the last sample). The pixel count returns to 0. Back-to-back words with no gap are legal.
- O_address_out holds the address used for that write. The internal counter increments after each write and wraps BLOCK_DEPTH-1 -> 0. O_block_done_out=1 together with the write at BLOCK_DEPTH-1.
- O_write_out and O_block_done_out are high for exactly one cycle per write. O_data_out and O_address_out hold their values until the next write.
- Line end with count>0:
  - Enter FLUSH.
  - Unfilled slots are zero.
  - The write occurs on the cycle after FLUSH is entered and consumes one address.
  - Line end with count=0 does nothing.
- I_valid_in and I_line_end_in in the same cycle: the sample is included first, then the flush rule applies. If that sample completes the word, it is a normal full write and no extra flush follows.
- I_valid_in during FLUSH: the sample is accepted as k=0 of the next word; no sample is lost.
- I_frame_start_in in any state except reset:
  - Discard the partial word (no write).
  - Count=0, address counter=0, go to PACK.
  - A write already registered for this cycle still completes.
  - If I_valid_in is also high, that sample is k=0 of the new frame.
- Reset has priority over all inputs. Reset mid-word discards the partial word; no write is emitted.

Test Plan:
- Frame start, then 8 valid samples ch0=0x00..0x07, ch1=0x10..0x17, ch2=0xF0..0xF7 -> one cycle after the 8th: O_write_out=1, addr 0, O_data_out[0]=64'h0706050403020100, [1]=64'h1716151413121110, [2]=64'hF7F6F5F4F3F2F1F0.
- 96 continuous samples after frame start -> 12 single-cycle writes, addresses 0..11. O_block_done_out only with addr 11; the next word is written at addr 0.
- 3 samples ch0=0xAA,0xBB,0xCC, line end with the 3rd sample -> write with O_data_out[0]=64'h0000000000CCBBAA, addr 0; the next full word goes to addr 1.
- 5 samples, then frame start with a valid sample 0x11 -> no write for the partial word; the next write is at addr 0 with byte0=0x11.
- Valid samples before any frame start, and line end while IDLE -> no writes, outputs stay 0.
- Reset (0) asserted after 4 samples of a word -> all outputs 0 next cycle. After release and frame start, addressing restarts at 0.

Source files
------------

// File: rtl/pixel_word_packer.sv
// Packs per-channel pixel samples into wide words and issues addressed write strobes
// for the bank distributor; supports frame restart and padded line-end flush.
module pixel_word_packer #(
    parameter int CHANNEL_NUMBER    = 3,
    parameter int PIXEL_BITS        = 8,
    parameter int PIXELS_PER_WORD   = 8,
    parameter int CHANNEL_BANDWIDTH = PIXEL_BITS * PIXELS_PER_WORD,
    parameter int BLOCK_DEPTH       = 12,
    parameter int GLOBAL_ADDR_BITS  = $clog2(BLOCK_DEPTH)
) (
    input  logic                                               I_clk_in,
    input  logic                                               I_rst_n_in,
    input  logic [CHANNEL_NUMBER-1:0][PIXEL_BITS-1:0]          I_pixel_in,
    input  logic                                               I_valid_in,
    input  logic                                               I_frame_start_in,
    input  logic                                               I_line_end_in,
    output logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0]   O_data_out,
    output logic [GLOBAL_ADDR_BITS-1:0]                        O_address_out,
    output logic                                               O_write_out,
    output logic                                               O_block_done_out
);
    localparam int CNT_W = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;

    typedef logic [CHANNEL_NUMBER-1:0][CHANNEL_BANDWIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [GLOBAL_ADDR_BITS-1:0] addr_q, addr_d;
    word_t                       word_q, word_d;
    word_t                       data_q, data_d;
    logic [GLOBAL_ADDR_BITS-1:0] oaddr_q, oaddr_d;
    logic                        write_q, write_d;
    logic                        done_q, done_d;

    logic                        emit;
    word_t                       emit_word;
    logic [CNT_W-1:0]            base_cnt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        word_d    = word_q;
        data_d    = data_q;
        oaddr_d   = oaddr_q;
        write_d   = 1'b0;
        done_d    = 1'b0;
        emit      = 1'b0;
        emit_word = word_q;
        base_cnt  = cnt_q;

        if (state_q != IDLE) begin
            // FLUSH drains the held partial word while the next word starts at slot 0.
            if (state_q == FLUSH) begin
                emit      = 1'b1;
                emit_word = word_q;
                word_d    = '0;
                base_cnt  = '0;
            end
            state_d = PACK;
            cnt_d   = base_cnt;
            if (I_valid_in) begin
                for (int c = 0; c < CHANNEL_NUMBER; c++)
                    word_d[c][int'(base_cnt)*PIXEL_BITS +: PIXEL_BITS] = I_pixel_in[c];
                if (base_cnt == CNT_W'(PIXELS_PER_WORD-1)) begin
                    emit      = 1'b1;
                    emit_word = word_d;
                    word_d    = '0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = base_cnt + CNT_W'(1);
                end
            end
            if (I_line_end_in && cnt_d != '0)
                state_d = FLUSH;
        end

        if (I_frame_start_in) begin
            emit    = 1'b0;
            state_d = PACK;
            addr_d  = '0;
            word_d  = '0;
            cnt_d   = '0;
            if (I_valid_in) begin
                for (int c = 0; c < CHANNEL_NUMBER; c++)
                    word_d[c][PIXEL_BITS-1:0] = I_pixel_in[c];
                cnt_d = CNT_W'(1);
            end
        end

        if (emit) begin
            data_d  = emit_word;
            oaddr_d = addr_q;
            write_d = 1'b1;
            done_d  = (addr_q == GLOBAL_ADDR_BITS'(BLOCK_DEPTH-1));
            addr_d  = done_d ? '0 : addr_q + GLOBAL_ADDR_BITS'(1);
        end
    end

    always_ff @(posedge I_clk_in) begin
        if (!I_rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            oaddr_q <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            data_q  <= data_d;
            oaddr_q <= oaddr_d;
            write_q <= write_d;
            done_q  <= done_d;
        end
    end

    assign O_data_out       = data_q;
    assign O_address_out    = oaddr_q;
    assign O_write_out      = write_q;
    assign O_block_done_out = done_q;
endmodule

// File: tb/tb_pixel_word_packer.sv
// Randomized self-checking bench for pixel_word_packer; a sample-list model predicts
// the ordered sequence of writes that a monitor collects from the DUT.
module tb_pixel_word_packer;
    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [2:0][7:0]      pixel;
    logic                 valid, fs, le;
    logic [2:0][63:0]     O_data_out;
    logic [3:0]           O_address_out;
    logic                 O_write_out, O_block_done_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0][63:0] data;
        logic [3:0]       addr;
        logic             done;
    } wr_t;

    wr_t             got_q[$];
    wr_t             exp_q[$];
    logic [2:0][7:0] cur[$];
    bit              in_frame;
    int              m_addr;

    pixel_word_packer dut (
        .I_clk_in         (clk),
        .I_rst_n_in       (rst_n),
        .I_pixel_in       (pixel),
        .I_valid_in       (valid),
        .I_frame_start_in (fs),
        .I_line_end_in    (le),
        .O_data_out       (O_data_out),
        .O_address_out    (O_address_out),
        .O_write_out      (O_write_out),
        .O_block_done_out (O_block_done_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (O_write_out) begin
            wr_t e;
            e.data = O_data_out;
            e.addr = O_address_out;
            e.done = O_block_done_out;
            got_q.push_back(e);
        end
    end

    // Reference: a word is the list of accepted samples, zero-padded, written in order.
    function automatic void m_emit();
        wr_t e;
        e.data = '0;
        for (int k = 0; k < cur.size(); k++)
            for (int c = 0; c < 3; c++)
                e.data[c][k*8 +: 8] = cur[k][c];
        e.addr = 4'(m_addr);
        e.done = (m_addr == 11);
        exp_q.push_back(e);
        m_addr = (m_addr + 1) % 12;
        cur.delete();
    endfunction

    function automatic void m_reset();
        in_frame = 0;
        m_addr   = 0;
        cur.delete();
    endfunction

    function automatic void m_step(input bit v, input logic [2:0][7:0] px, input bit f, input bit l);
        if (f) begin
            cur.delete();
            m_addr   = 0;
            in_frame = 1;
            if (v) cur.push_back(px);
        end else if (in_frame) begin
            if (v) cur.push_back(px);
            if (cur.size() == 8) m_emit();
            else if (l && cur.size() > 0) m_emit();
        end
    endfunction

    task automatic cyc(input bit v, input logic [2:0][7:0] px, input bit f, input bit l);
        valid = v; pixel = px; fs = f; le = l;
        if (rst_n) m_step(v, px, f, l);
        @(posedge clk); #1;
        valid = 0; fs = 0; le = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        cyc(0, '0, 0, 0);
        m_reset();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        valid = 0; fs = 0; le = 0; pixel = '0;
        cyc(1, 24'hABCDEF, 1, 0);
        cyc(0, '0, 0, 0);
        m_reset();
        checks++;
        if (O_data_out !== '0) begin
            errors++; $display("FAIL reset_data got %h want 0", O_data_out);
        end
        checks++;
        if ({O_address_out, O_write_out, O_block_done_out} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got addr=%0d wr=%b done=%b want 0", O_address_out, O_write_out, O_block_done_out);
        end
        rst_n = 1;
    endtask

    task automatic test_single_word();
        cyc(0, '0, 1, 0);
        for (int k = 0; k < 8; k++)
            cyc(1, {8'(8'hF0 + k), 8'(8'h10 + k), 8'(k)}, 0, 0);
        checks++;
        if (O_write_out !== 1'b1 || O_address_out !== 4'd0 || O_block_done_out !== 1'b0) begin
            errors++; $display("FAIL single_ctrl got wr=%b addr=%0d done=%b want 1 0 0", O_write_out, O_address_out, O_block_done_out);
        end
        checks++;
        if (O_data_out !== {64'hF7F6F5F4F3F2F1F0, 64'h1716151413121110, 64'h0706050403020100}) begin
            errors++; $display("FAIL single_data got %h", O_data_out);
        end
        cyc(0, '0, 0, 0);
        checks++;
        if (O_write_out !== 1'b0 || O_data_out[0] !== 64'h0706050403020100) begin
            errors++; $display("FAIL single_hold got wr=%b d0=%h want 0 0706050403020100", O_write_out, O_data_out[0]);
        end
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL single_model got %0d writes want %0d", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_block_wrap();
        cyc(0, '0, 1, 0);
        for (int k = 0; k < 104; k++) cyc(1, 24'($urandom()), 0, 0);
        repeat (3) cyc(0, '0, 0, 0);
        checks++;
        if (got_q.size() != 13 || exp_q.size() != 13) begin
            errors++; $display("FAIL wrap_count got %0d want 13", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL wrap_write[%0d] got addr=%0d done=%b d=%h want addr=%0d done=%b d=%h", i, got_q[i].addr, got_q[i].done, got_q[i].data, exp_q[i].addr, exp_q[i].done, exp_q[i].data);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_line_end();
        cyc(0, '0, 1, 0);
        cyc(1, {8'h03, 8'h02, 8'hAA}, 0, 0);
        cyc(1, {8'h13, 8'h12, 8'hBB}, 0, 0);
        cyc(1, {8'h23, 8'h22, 8'hCC}, 0, 1);
        for (int k = 0; k < 8; k++) cyc(1, 24'($urandom()), 0, 0);
        repeat (3) cyc(0, '0, 0, 0);
        checks++;
        if (got_q.size() < 1) begin
            errors++; $display("FAIL flush_word got no write want addr 0");
        end else if (got_q[0].data[0] !== 64'h0000000000CCBBAA || got_q[0].addr !== 4'd0) begin
            errors++; $display("FAIL flush_word got d0=%h addr=%0d want 0000000000CCBBAA 0", got_q[0].data[0], got_q[0].addr);
        end
        checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() != 2) begin
            errors++; $display("FAIL flush_count got %0d want 2", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL flush_write[%0d] got addr=%0d d=%h want addr=%0d d=%h", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame_restart();
        cyc(0, '0, 1, 0);
        for (int k = 0; k < 5; k++) cyc(1, 24'($urandom()), 0, 0);
        cyc(1, {8'h11, 8'h11, 8'h11}, 1, 0);
        for (int k = 0; k < 7; k++) cyc(1, 24'($urandom()), 0, 0);
        repeat (3) cyc(0, '0, 0, 0);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL restart_count got %0d want 1", got_q.size());
        end else if (got_q[0].addr !== 4'd0 || got_q[0].data[0][7:0] !== 8'h11 || got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL restart_word got addr=%0d b0=%h want 0 11", got_q[0].addr, got_q[0].data[0][7:0]);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_idle_ignore();
        do_reset();
        for (int k = 0; k < 12; k++) cyc(1, 24'($urandom()), 0, (k % 4) == 3);
        repeat (3) cyc(0, '0, 0, 0);
        checks++;
        if (got_q.size() != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL idle_writes got %0d want 0", got_q.size());
        end
        checks++;
        if (O_data_out !== '0 || O_address_out !== 4'd0 || O_block_done_out !== 1'b0) begin
            errors++; $display("FAIL idle_outputs got d=%h addr=%0d want 0", O_data_out, O_address_out);
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_word();
        cyc(0, '0, 1, 0);
        for (int k = 0; k < 12; k++) cyc(1, 24'($urandom() | 1), 0, 0);
        do_reset();
        checks++;
        if (O_data_out !== '0 || O_address_out !== 4'd0 || O_write_out !== 1'b0 || O_block_done_out !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got d=%h addr=%0d wr=%b want 0", O_data_out, O_address_out, O_write_out);
        end
        cyc(0, '0, 1, 0);
        for (int k = 0; k < 8; k++) cyc(1, 24'($urandom()), 0, 0);
        repeat (3) cyc(0, '0, 0, 0);
        checks++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            errors++; $display("FAIL midreset_count got %0d want 2", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL midreset_write[%0d] got addr=%0d d=%h want addr=%0d d=%h", i, got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit prev_le = 0;
        cyc(0, '0, 1, 0);
        for (int k = 0; k < 600; k++) begin
            bit v = ($urandom_range(9) < 7);
            bit l = ($urandom_range(11) == 0);
            bit f = !prev_le && ($urandom_range(59) == 0);
            cyc(v, 24'($urandom()), f, l);
            prev_le = l;
        end
        repeat (3) cyc(0, '0, 0, 0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL random_write[%0d] got addr=%0d done=%b d=%h want addr=%0d done=%b d=%h", i, got_q[i].addr, got_q[i].done, got_q[i].data, exp_q[i].addr, exp_q[i].done, exp_q[i].data);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_block_wrap();
        test_line_end();
        test_frame_restart();
        test_idle_ignore();
        test_reset_mid_word();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
